laplacian_scan_ctrl: RTL and testbench

Raster-scan sequencer for the streaming 3x3 Laplacian datapath. It accepts one frame of pixels in raster order and drives the line-buffer write enable and column address and the window-shift strobe. It also emits a registered output-control stream that tags every output position with its row, column and border flag. The controller sits between the pixel source and the line-buffer/kernel datapath and owns all frame-level handshaking (start, busy, done, abort).

---
 rtl/lap_pkg.sv | 23 ++
 rtl/lap_rc_counter.sv | 41 ++++
 rtl/laplacian_scan_ctrl.sv | 163 ++++++++++++++++
 tb/tb_laplacian_scan_ctrl.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lap_pkg.sv
// Shared types, default frame geometry and border helper for the Laplacian scan controller.
package lap_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        RUN,
        FLUSH
    } lap_ctrl_state_t;

    localparam int unsigned LAP_ROWS_DEF = 242;
    localparam int unsigned LAP_COLS_DEF = 247;

    function automatic logic lap_is_border(
        input int unsigned row,
        input int unsigned col,
        input int unsigned rows,
        input int unsigned cols
    );
        return (row == 0) || (row == rows - 1) || (col == 0) || (col == cols - 1);
    endfunction

endpackage

// File: rtl/lap_rc_counter.sv
// Raster row/column position counter; column wraps at COLS-1 and carries into the row.
module lap_rc_counter
    import lap_pkg::*;
#(
    parameter int unsigned ROWS = LAP_ROWS_DEF,
    parameter int unsigned COLS = LAP_COLS_DEF,
    localparam int unsigned RW  = $clog2(ROWS),
    localparam int unsigned CW  = $clog2(COLS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          inc,
    output logic [RW-1:0] row,
    output logic [CW-1:0] col,
    output logic          at_last
);

    localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row <= '0;
            col <= '0;
        end else if (clr) begin
            row <= '0;
            col <= '0;
        end else if (inc) begin
            if (col == COL_LAST) begin
                col <= '0;
                row <= (row == ROW_LAST) ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    assign at_last = (row == ROW_LAST) && (col == COL_LAST);

endmodule

// File: rtl/laplacian_scan_ctrl.sv
// Raster-scan sequencer for the 3x3 Laplacian datapath (line-buffer strobes + output tagging).
// Optional LAP_CTRL_STALL_CNT_EN adds a saturating output-stall cycle counter.
module laplacian_scan_ctrl
    import lap_pkg::*;
#(
    parameter int unsigned ROWS = LAP_ROWS_DEF,
    parameter int unsigned COLS = LAP_COLS_DEF,
    localparam int unsigned RW  = $clog2(ROWS),
    localparam int unsigned CW  = $clog2(COLS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          lb_wr_en,
    output logic [CW-1:0] lb_addr,
    output logic          win_shift,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [RW-1:0] out_row,
    output logic [CW-1:0] out_col,
    output logic          out_border,
    output logic          busy,
    output logic          done
`ifdef LAP_CTRL_STALL_CNT_EN
    ,
    output logic [15:0]   stall_cnt
`endif
);

    lap_ctrl_state_t state_q, state_d;

    logic [RW-1:0] in_row;
    logic [CW-1:0] in_col;
    logic          in_last;
    logic          out_last;
    logic          out_valid_q;
    logic          done_q;
    logic          adv;
    logic          adv_out;
    logic          hs;
    logic          out_free;
    logic          final_hs;
    logic          start_acc;
    logic          cnt_clr;
    logic          in_inc;

    assign out_free  = !out_valid_q || out_ready;
    assign hs        = out_valid_q && out_ready;
    assign start_acc = (state_q == IDLE) && start && !abort;
    assign cnt_clr   = abort || start_acc;
    assign in_inc    = adv && ((state_q == FILL) || (state_q == RUN));
    assign adv_out   = adv && ((state_q == RUN) || (state_q == FLUSH));

    lap_rc_counter #(
        .ROWS (ROWS),
        .COLS (COLS)
    ) u_in_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (cnt_clr),
        .inc     (in_inc),
        .row     (in_row),
        .col     (in_col),
        .at_last (in_last)
    );

    lap_rc_counter #(
        .ROWS (ROWS),
        .COLS (COLS)
    ) u_out_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (cnt_clr),
        .inc     (hs),
        .row     (out_row),
        .col     (out_col),
        .at_last (out_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        adv      = 1'b0;
        in_ready = 1'b0;
        final_hs = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) state_d = FILL;
            end
            FILL: begin
                in_ready = 1'b1;
                adv      = in_valid;
                // L-th accept is raster index COLS, i.e. position (1,0)
                if (adv && (in_row == RW'(1)) && (in_col == '0)) state_d = RUN;
            end
            RUN: begin
                in_ready = out_free;
                adv      = in_valid && out_free;
                if (adv && in_last) state_d = FLUSH;
            end
            FLUSH: begin
                // no advance once the final position is already loaded
                adv      = out_free && !(out_valid_q && out_last);
                final_hs = hs && out_last;
                if (final_hs) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (abort) state_d = IDLE;
    end

    // Output counter already holds the next raster position, so a load only raises valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= final_hs && !abort;
            if (abort) begin
                out_valid_q <= 1'b0;
            end else if (adv_out) begin
                out_valid_q <= 1'b1;
            end else if (hs) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign lb_wr_en   = in_inc;
    assign lb_addr    = in_col;
    assign win_shift  = adv;
    assign out_valid  = out_valid_q;
    assign out_border = lap_is_border(32'(out_row), 32'(out_col), ROWS, COLS);
    assign busy       = (state_q != IDLE);
    assign done       = done_q;

`ifdef LAP_CTRL_STALL_CNT_EN
    logic [15:0] stall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else if (start_acc) begin
            stall_q <= '0;
        end else if (out_valid_q && !out_ready && (stall_q != '1)) begin
            stall_q <= stall_q + 1'b1;
        end
    end

    assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_laplacian_scan_ctrl.sv
// Randomized self-checking bench for laplacian_scan_ctrl on a 4x5 frame.
module tb_laplacian_scan_ctrl;

    localparam int R   = 4;
    localparam int C   = 5;
    localparam int L   = C + 1;
    localparam int N   = R * C;
    localparam int RWB = $clog2(R);
    localparam int CWB = $clog2(C);

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic           abort = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic           lb_wr_en;
    logic [CWB-1:0] lb_addr;
    logic           win_shift;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [RWB-1:0] out_row;
    logic [CWB-1:0] out_col;
    logic           out_border;
    logic           busy;
    logic           done;
`ifdef LAP_CTRL_STALL_CNT_EN
    logic [15:0]    stall_cnt;
`endif

    int checks = 0;
    int failures = 0;

    laplacian_scan_ctrl #(
        .ROWS (R),
        .COLS (C)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .lb_wr_en   (lb_wr_en),
        .lb_addr    (lb_addr),
        .win_shift  (win_shift),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_row    (out_row),
        .out_col    (out_col),
        .out_border (out_border),
        .busy       (busy),
        .done       (done)
`ifdef LAP_CTRL_STALL_CNT_EN
        ,
        .stall_cnt  (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1, "global timeout");
    end

    // One frame: reference is the raster index sequence 0..N-1 with border from row/col arithmetic.
    task automatic run_frame(input int p_in, input int p_out, input int stall_lo, input int stall_hi,
                             input int poke, input bit chain, input bit started,
                             output int cyc, output int nb, output int ws, output int stalls);
        int acc, idx, r, c;
        bit seen_ov, prev_stall, accept, exp_b;
        logic [RWB-1:0] prev_row;
        logic [CWB-1:0] prev_col;
        acc = 0; idx = 0; cyc = 0; nb = 0; ws = 0; stalls = 0;
        seen_ov = 0; prev_stall = 0; prev_row = '0; prev_col = '0;
        if (!started) begin
            @(posedge clk); #1;
            start = 1'b1; abort = 1'b0; in_valid = 1'($urandom_range(1)); out_ready = 1'b1;
            @(negedge clk);
            checks++;
            if (busy !== 1'b0 || in_ready !== 1'b0) begin
                failures++; $display("FAIL idle_before_start busy=%b in_ready=%b want 0 0", busy, in_ready);
            end
        end
        for (int i = 0; i < 40 * N + 200 && idx < N; i++) begin
            @(posedge clk); #1;
            start     = (i == poke);
            in_valid  = (int'($urandom_range(99)) < p_in);
            out_ready = (i >= stall_lo && i <= stall_hi) ? 1'b0 : (int'($urandom_range(99)) < p_out);
            @(negedge clk);
            cyc++;
            checks++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                failures++; $display("FAIL in_frame cyc=%0d busy=%b done=%b want 1 0", i, busy, done);
            end
`ifdef LAP_CTRL_STALL_CNT_EN
            if (i == 0) begin
                checks++;
                if (stall_cnt !== 16'd0) begin
                    failures++; $display("FAIL stall_clear got=%0d want 0", stall_cnt);
                end
            end
`endif
            if (acc < L) begin
                checks++;
                if (in_ready !== 1'b1) begin
                    failures++; $display("FAIL fill_ready acc=%0d got=%b want 1", acc, in_ready);
                end
            end
            if (acc == N) begin
                checks++;
                if (in_ready !== 1'b0) begin
                    failures++; $display("FAIL flush_ready got=%b want 0", in_ready);
                end
            end
            if (out_valid === 1'b1 && out_ready === 1'b0) begin
                stalls++;
                checks++;
                if (in_ready !== 1'b0) begin
                    failures++; $display("FAIL stall_ready cyc=%0d got=%b want 0", i, in_ready);
                end
            end
            if (prev_stall) begin
                checks++;
                if (out_valid !== 1'b1 || out_row !== prev_row || out_col !== prev_col) begin
                    failures++;
                    $display("FAIL stall_hold got v=%b (%0d,%0d) want v=1 (%0d,%0d)",
                             out_valid, out_row, out_col, prev_row, prev_col);
                end
            end
            if (out_valid === 1'b1 && !seen_ov) begin
                seen_ov = 1;
                checks++;
                if (acc != L + 1) begin
                    failures++; $display("FAIL first_valid accepts=%0d want %0d", acc, L + 1);
                end
            end
            if (win_shift === 1'b1) ws++;
            accept = (in_valid === 1'b1) && (in_ready === 1'b1);
            checks++;
            if (lb_wr_en !== accept) begin
                failures++; $display("FAIL lb_wr_en cyc=%0d got=%b want %b", i, lb_wr_en, accept);
            end
            if (accept) begin
                checks++;
                if (lb_addr !== CWB'(acc % C)) begin
                    failures++; $display("FAIL lb_addr acc=%0d got=%0d want %0d", acc, lb_addr, acc % C);
                end
                acc++;
            end
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                r = idx / C;
                c = idx % C;
                exp_b = (r == 0) || (r == R - 1) || (c == 0) || (c == C - 1);
                checks++;
                if (out_row !== RWB'(r) || out_col !== CWB'(c) || out_border !== exp_b) begin
                    failures++;
                    $display("FAIL out_pos idx=%0d got (%0d,%0d,b%b) want (%0d,%0d,b%b)",
                             idx, out_row, out_col, out_border, r, c, exp_b);
                end
                if (!exp_b) nb++;
                idx++;
            end
            prev_stall = (out_valid === 1'b1) && (out_ready === 1'b0);
            prev_row   = out_row;
            prev_col   = out_col;
        end
        checks++;
        if (idx != N) begin
            failures++; $display("FAIL frame_timeout outputs=%0d want %0d", idx, N);
        end else begin
            @(posedge clk); #1;
            start = chain; in_valid = 1'b0; out_ready = 1'b1;
            @(negedge clk);
            checks++;
            if (done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
                failures++;
                $display("FAIL done_cycle got done=%b busy=%b ov=%b want 1 0 0", done, busy, out_valid);
            end
`ifdef LAP_CTRL_STALL_CNT_EN
            checks++;
            if (stall_cnt !== 16'(stalls)) begin
                failures++; $display("FAIL stall_cnt got=%0d want %0d", stall_cnt, stalls);
            end
`endif
            if (!chain) begin
                @(posedge clk); #1;
                start = 1'b0;
                @(negedge clk);
                checks++;
                if (done !== 1'b0) begin
                    failures++; $display("FAIL done_width got=%b want 0", done);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || done !== 1'b0 || in_ready !== 1'b0 ||
            lb_wr_en !== 1'b0 || win_shift !== 1'b0 || out_row !== '0 || out_col !== '0) begin
            failures++;
            $display("FAIL reset_state busy=%b ov=%b done=%b rdy=%b we=%b ws=%b pos=(%0d,%0d) want all 0",
                     busy, out_valid, done, in_ready, lb_wr_en, win_shift, out_row, out_col);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_continuous();
        int cyc, nb, ws, st;
        run_frame(100, 100, -1, -1, -1, 1'b0, 1'b0, cyc, nb, ws, st);
        checks++;
        if (cyc != N + 1 + L || nb != (R - 2) * (C - 2) || ws != N + L || st != 0) begin
            failures++;
            $display("FAIL continuous cyc=%0d nb=%0d ws=%0d st=%0d want %0d %0d %0d 0",
                     cyc, nb, ws, st, N + 1 + L, (R - 2) * (C - 2), N + L);
        end
    endtask

    task automatic test_backpressure();
        int cyc, nb, ws, st;
        run_frame(100, 100, 10, 12, -1, 1'b0, 1'b0, cyc, nb, ws, st);
        checks++;
        if (st != 3 || cyc != N + 1 + L + 3) begin
            failures++; $display("FAIL backpressure stalls=%0d cyc=%0d want 3 %0d", st, cyc, N + 4 + L);
        end
    endtask

    task automatic test_start_ignored();
        int cyc, nb, ws, st;
        run_frame(100, 100, -1, -1, 8, 1'b0, 1'b0, cyc, nb, ws, st);
        checks++;
        if (cyc != N + 1 + L) begin
            failures++; $display("FAIL start_busy cyc=%0d want %0d", cyc, N + 1 + L);
        end
    endtask

    task automatic test_abort();
        int cyc, nb, ws, st;
        @(posedge clk); #1;
        start = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        repeat (12) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b0 || done !== 1'b0 ||
            out_row !== '0 || out_col !== '0) begin
            failures++;
            $display("FAIL abort_state busy=%b ov=%b rdy=%b done=%b pos=(%0d,%0d) want all 0",
                     busy, out_valid, in_ready, done, out_row, out_col);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0) begin
                failures++; $display("FAIL abort_no_done k=%0d got=%b want 0", k, done);
            end
        end
        @(posedge clk); #1;
        start = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++; $display("FAIL abort_over_start busy=%b want 0", busy);
        end
        run_frame(100, 100, -1, -1, -1, 1'b0, 1'b0, cyc, nb, ws, st);
        checks++;
        if (cyc != N + 1 + L || nb != (R - 2) * (C - 2)) begin
            failures++; $display("FAIL after_abort cyc=%0d nb=%0d want %0d %0d", cyc, nb, N + 1 + L, (R - 2) * (C - 2));
        end
    endtask

    task automatic test_back_to_back();
        int cyc, nb, ws, st;
        run_frame(100, 100, 11, 11, -1, 1'b1, 1'b0, cyc, nb, ws, st);
        run_frame(100, 100, -1, -1, -1, 1'b0, 1'b1, cyc, nb, ws, st);
        checks++;
        if (cyc != N + 1 + L) begin
            failures++; $display("FAIL back_to_back cyc=%0d want %0d", cyc, N + 1 + L);
        end
    endtask

    task automatic test_random();
        int cyc, nb, ws, st;
        for (int k = 0; k < 5; k++) begin
            run_frame(int'($urandom_range(100, 30)), int'($urandom_range(100, 30)), -1, -1, -1,
                      1'b0, 1'b0, cyc, nb, ws, st);
            checks++;
            if (ws != N + L || nb != (R - 2) * (C - 2)) begin
                failures++; $display("FAIL random k=%0d ws=%0d nb=%0d want %0d %0d", k, ws, nb, N + L, (R - 2) * (C - 2));
            end
        end
    endtask

    task automatic test_reset_midrun();
        int cyc, nb, ws, st;
        @(posedge clk); #1;
        start = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        repeat (12) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || done !== 1'b0 || in_ready !== 1'b0 ||
            out_row !== '0 || out_col !== '0) begin
            failures++;
            $display("FAIL reset_midrun busy=%b ov=%b done=%b rdy=%b pos=(%0d,%0d) want all 0",
                     busy, out_valid, done, in_ready, out_row, out_col);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_frame(100, 100, -1, -1, -1, 1'b0, 1'b0, cyc, nb, ws, st);
        checks++;
        if (cyc != N + 1 + L) begin
            failures++; $display("FAIL after_reset cyc=%0d want %0d", cyc, N + 1 + L);
        end
    endtask

    initial begin
        test_reset();
        test_continuous();
        test_backpressure();
        test_start_ignored();
        test_abort();
        test_back_to_back();
        test_random();
        test_reset_midrun();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
